// File: rtl/led_pattern_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_pattern_seq_pkg
//  Description : Shared encodings for the LED pattern sequencer.
//                LED_PATTERN_BOUNCE_EN enables the BOUNCE mode.
//  Revision    : 1.0  initial release
// ============================================================================
package led_pattern_seq_pkg;

  localparam logic [1:0] MODE_OFF    = 2'd0;
  localparam logic [1:0] MODE_BLINK  = 2'd1;
  localparam logic [1:0] MODE_SHIFT  = 2'd2;
  localparam logic [1:0] MODE_BOUNCE = 2'd3;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Without BOUNCE support, mode 3 is folded onto SHIFT so it is indistinguishable from it.
  function automatic logic [1:0] effective_mode(input logic [1:0] mode);
`ifdef LED_PATTERN_BOUNCE_EN
    return mode;
`else
    return (mode == MODE_BOUNCE) ? MODE_SHIFT : mode;
`endif
  endfunction

endpackage
`default_nettype wire

// File: rtl/toggle_edge_det.sv
`default_nettype none
// ============================================================================
//  Module      : toggle_edge_det
//  Description : Flags either edge of a synchronous square wave.
//  Revision    : 1.0  initial release
// ============================================================================
module toggle_edge_det (
  input  logic clk,
  input  logic reset,
  input  logic i_sig,
  output logic o_pulse
);

  logic r_sig_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sig_d <= 1'b0;
    end else begin
      r_sig_d <= i_sig;
    end
  end

  assign o_pulse = (i_sig != r_sig_d);

endmodule
`default_nettype wire

// File: rtl/led_pattern_seq.sv
`default_nettype none
// ============================================================================
//  Module      : led_pattern_seq
//  Description : LED pattern sequencer (OFF / BLINK / SHIFT / BOUNCE) stepped by
//                toggle edges. BOUNCE and its direction register exist only
//                when LED_PATTERN_BOUNCE_EN is defined.
//  Revision    : 1.0  initial release
// ============================================================================
module led_pattern_seq
  import led_pattern_seq_pkg::*;
#(
  parameter int NUM_LED = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_enable,
  input  logic               i_toggle,
  input  logic [1:0]         i_mode,
  output logic [NUM_LED-1:0] o_led,
  output logic               o_step,
  output logic               o_wrap
);

  localparam logic [NUM_LED-1:0] c_all_ones = {NUM_LED{1'b1}};
  localparam logic [NUM_LED-1:0] c_lsb      = {{(NUM_LED-1){1'b0}}, 1'b1};

  logic               w_step;
  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic [1:0]         r_mode_q;
  logic [1:0]         w_mode_nxt;
  logic [1:0]         w_mode_eff;
  logic [NUM_LED-1:0] r_led;
  logic [NUM_LED-1:0] w_led_nxt;
  logic [NUM_LED-1:0] w_led_init;
  logic [NUM_LED-1:0] w_led_adv;
  logic               r_step;
  logic               w_step_nxt;
  logic               r_wrap;
  logic               w_wrap_nxt;
  logic               w_wrap_adv;
`ifdef LED_PATTERN_BOUNCE_EN
  logic               r_dir;
  logic               w_dir_nxt;
  logic               w_dir_adv;
`endif

  toggle_edge_det u_edge_det (
    .clk     (clk),
    .reset   (reset),
    .i_sig   (i_toggle),
    .o_pulse (w_step)
  );

  assign w_mode_eff = effective_mode(i_mode);

  always_comb begin
    w_led_init = c_lsb;
    if (w_mode_eff == MODE_OFF) begin
      w_led_init = '0;
    end else if (w_mode_eff == MODE_BLINK) begin
      w_led_init = c_all_ones;
    end
  end

  // One advance of the currently latched pattern.
  always_comb begin
    w_led_adv  = '0;
    w_wrap_adv = 1'b0;
`ifdef LED_PATTERN_BOUNCE_EN
    w_dir_adv  = r_dir;
`endif
    case (r_mode_q)
      MODE_BLINK: begin
        w_led_adv  = ~r_led;
        w_wrap_adv = (r_led == '0);
      end
      MODE_SHIFT: begin
        w_led_adv  = {r_led[NUM_LED-2:0], r_led[NUM_LED-1]};
        w_wrap_adv = r_led[NUM_LED-1];
      end
`ifdef LED_PATTERN_BOUNCE_EN
      MODE_BOUNCE: begin
        if (r_dir == DIR_LEFT) begin
          w_led_adv = r_led << 1;
          if (r_led[NUM_LED-2]) begin
            w_dir_adv = DIR_RIGHT;
          end
        end else begin
          w_led_adv = r_led >> 1;
          if (r_led[1]) begin
            w_dir_adv  = DIR_LEFT;
            w_wrap_adv = 1'b1;
          end
        end
      end
`endif
      default: begin
        w_led_adv  = '0;
        w_wrap_adv = 1'b0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_mode_q <= MODE_OFF;
      r_led    <= '0;
      r_step   <= 1'b0;
      r_wrap   <= 1'b0;
`ifdef LED_PATTERN_BOUNCE_EN
      r_dir    <= DIR_LEFT;
`endif
    end else begin
      r_state  <= w_state_nxt;
      r_mode_q <= w_mode_nxt;
      r_led    <= w_led_nxt;
      r_step   <= w_step_nxt;
      r_wrap   <= w_wrap_nxt;
`ifdef LED_PATTERN_BOUNCE_EN
      r_dir    <= w_dir_nxt;
`endif
    end
  end

  // Next state: a mode change outranks a step, and the entry cycle ignores steps.
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode_q;
    w_led_nxt   = r_led;
    w_step_nxt  = 1'b0;
    w_wrap_nxt  = 1'b0;
`ifdef LED_PATTERN_BOUNCE_EN
    w_dir_nxt   = r_dir;
`endif
    case (r_state)
      ST_IDLE: begin
        if (i_enable) begin
          w_state_nxt = ST_RUN;
          w_mode_nxt  = w_mode_eff;
          w_led_nxt   = w_led_init;
`ifdef LED_PATTERN_BOUNCE_EN
          w_dir_nxt   = DIR_LEFT;
`endif
        end else begin
          w_led_nxt = '0;
        end
      end
      default: begin
        if (!i_enable) begin
          w_state_nxt = ST_IDLE;
          w_led_nxt   = '0;
        end else if (w_mode_eff != r_mode_q) begin
          w_mode_nxt = w_mode_eff;
          w_led_nxt  = w_led_init;
`ifdef LED_PATTERN_BOUNCE_EN
          w_dir_nxt  = DIR_LEFT;
`endif
        end else if (w_step) begin
          w_led_nxt  = w_led_adv;
          w_step_nxt = 1'b1;
          w_wrap_nxt = w_wrap_adv;
`ifdef LED_PATTERN_BOUNCE_EN
          w_dir_nxt  = w_dir_adv;
`endif
        end
      end
    endcase
  end

  // Outputs
  always_comb begin
    o_led  = r_led;
    o_step = r_step;
    o_wrap = r_wrap;
  end

endmodule
`default_nettype wire
